if_stage_fq: RTL and testbench

IF_STAGE_FQ -- requirements
Module: if_stage_fq

---
 rtl/riscv_pkg.sv | 7 +
 rtl/if_sync_fifo.sv | 71 +++++++
 rtl/if_stage_fq.sv | 171 +++++++++++++++++
 tb/tb_if_stage_fq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch front end.
//   RV_XLEN : default address/instruction width
//   RV_NOP  : canonical NOP (addi x0, x0, 0) used as the IF/ID bubble
package riscv_pkg;
  localparam int          RV_XLEN = 32;
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;
endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO used for both the fetch queue and the in-order PC tag FIFO.
// Handles any DEPTH >= 1 (pointers wrap explicitly), and accepts a push while
// full if a pop happens in the same cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clr          : synchronous clear (drops all entries, wins over push)
//   push, wdata  : write request and data (ignored when full without pop)
//   pop          : read request (ignored when empty)
//   rdata        : head entry (combinational, stale when empty)
//   full, empty, count : occupancy status
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_d  = do_pop  ? bump(rd_q) : rd_q;
    wr_d  = do_push ? bump(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !reset) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/if_stage_fq.sv
// Instruction fetch stage with a decoupling fetch queue.
// Issues in-order imem requests, tags each accepted request with its PC,
// buffers responses in a DEPTH-entry queue and presents them through the
// IF/ID register. Redirects and flushes squash the queue and mark all
// outstanding responses for discard.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   stall, flush              : decode hold / squash IF/ID + queue + in-flight
//   pc_src, new_pc            : fetch redirect (target word-aligned)
//   imem_addr/read/ready      : request channel (valid/ready)
//   imem_rvalid/data          : in-order response channel
//   if_id_pc/instruction/valid: IF/ID register
// Optional: define IF_STAGE_FQ_PERF_EN to add perf_fetch_cnt, perf_drop_cnt,
// perf_bubble_cnt (32-bit wrapping counters).
module if_stage_fq
  import riscv_pkg::*;
#(
  parameter int              XLEN            = RV_XLEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            pc_src,
  input  logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_read,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid
`ifdef IF_STAGE_FQ_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = QCW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(RV_NOP);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [TCW-1:0]    disc_q, disc_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d, id_ins_q, id_ins_d;
  logic              id_vld_q, id_vld_d;
  logic              kill, accept, rv, drop, q_push, q_pop;
  logic [XLEN-1:0]   tag_pc;
  logic              tag_full, tag_empty;
  logic [TCW-1:0]    tag_cnt;
  logic              q_full, q_empty;
  logic [QCW-1:0]    q_cnt;
  logic [2*XLEN-1:0] q_head;

  assign kill = pc_src | flush;
  // The tag FIFO count is the in-flight count: tags of discarded responses
  // stay in it until their response returns, so they still hold a slot.
  assign imem_read = ~reset & ~kill & ~tag_full & ~q_full &
                     ((SW'(tag_cnt) + SW'(q_cnt)) < SW'(DEPTH));
  assign imem_addr = pc_q;
  assign accept    = imem_read & imem_ready;
  // Responses with nothing outstanding are ignored.
  assign rv        = imem_rvalid & ~tag_empty;
  // A response landing in the redirect/flush cycle is dropped as well.
  assign drop      = rv & (kill | (disc_q != '0));
  assign q_push    = rv & ~drop;
  assign q_pop     = ~stall & ~flush & ~q_empty;

  if_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .push  (accept),
    .wdata (pc_q),
    .pop   (rv),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_cnt)
  );

  if_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fetch_q (
    .clk   (clk),
    .reset (reset),
    .clr   (kill),
    .push  (q_push),
    .wdata ({tag_pc, imem_data}),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  always_comb begin
    pc_d = pc_q;
    if (pc_src)      pc_d = {new_pc[XLEN-1:2], 2'b00};
    else if (accept) pc_d = pc_q + XLEN'(4);

    // Everything still outstanding after this cycle's response is stale.
    disc_d = disc_q;
    if (kill)      disc_d = tag_cnt - TCW'(rv);
    else if (drop) disc_d = disc_q - TCW'(1);

    id_pc_d  = id_pc_q;
    id_ins_d = id_ins_q;
    id_vld_d = id_vld_q;
    if (flush || (!stall && q_empty)) begin
      id_pc_d  = '0;
      id_ins_d = NOP;
      id_vld_d = 1'b0;
    end else if (!stall) begin
      id_pc_d  = q_head[2*XLEN-1:XLEN];
      id_ins_d = q_head[XLEN-1:0];
      id_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      disc_q   <= '0;
      id_pc_q  <= '0;
      id_ins_q <= NOP;
      id_vld_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      disc_q   <= disc_d;
      id_pc_q  <= id_pc_d;
      id_ins_q <= id_ins_d;
      id_vld_q <= id_vld_d;
    end
  end

  assign if_id_pc          = id_pc_q;
  assign if_id_instruction = id_ins_q;
  assign if_id_valid       = id_vld_q;

`ifdef IF_STAGE_FQ_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q  + 32'(accept);
    drop_cnt_d   = drop_cnt_q   + 32'(drop);
    bubble_cnt_d = bubble_cnt_q + 32'(~stall & q_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_drop_cnt   = drop_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the fetch stage.
module tb_if_stage_fq;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, pc_src = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] if_id_pc, if_id_instruction;
  logic        if_id_valid;
`ifdef IF_STAGE_FQ_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_bubble_cnt;
`endif

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  if_stage_fq #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src), .new_pc(new_pc),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_data(imem_data),
    .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid)
`ifdef IF_STAGE_FQ_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_tags[$];
  int          m_disc;
  logic [63:0] m_q[$];
  logic [31:0] m_id_pc, m_id_ins;
  logic        m_id_v;
  int unsigned m_fetch, m_drops, m_bubbles;
  // Memory side: addresses accepted by the DUT, answered in order
  logic [31:0] mem_pend[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return {a[15:0], 16'h0013} ^ 32'h5a5a_0000;
  endfunction

  function automatic bit model_read();
    return !reset && !pc_src && !flush && (m_tags.size() < MAXO) &&
           (m_tags.size() + m_q.size() < DEPTH);
  endfunction

  task automatic model_edge();
    bit rd, acc, rv, kill, qne;
    logic [31:0] tpc;
    logic [63:0] head;
    if (reset) begin
      m_pc = 32'h0; m_tags.delete(); m_disc = 0; m_q.delete();
      m_id_pc = 32'h0; m_id_ins = NOP; m_id_v = 1'b0;
      m_fetch = 0; m_drops = 0; m_bubbles = 0;
      return;
    end
    rd   = model_read();
    acc  = rd && imem_ready;
    kill = pc_src || flush;
    rv   = imem_rvalid && (m_tags.size() > 0);
    qne  = (m_q.size() > 0);
    head = qne ? m_q[0] : 64'h0;
    if (!stall && !qne) m_bubbles++;
    if (flush || (!stall && !qne)) begin
      m_id_pc = 32'h0; m_id_ins = NOP; m_id_v = 1'b0;
    end else if (!stall) begin
      m_id_pc = head[63:32]; m_id_ins = head[31:0]; m_id_v = 1'b1;
      void'(m_q.pop_front());
    end
    if (rv) begin
      tpc = m_tags.pop_front();
      if (kill || m_disc > 0) begin
        m_drops++;
        if (!kill) m_disc--;
      end else m_q.push_back({tpc, imem_data});
    end
    if (kill) begin
      m_q.delete();
      m_disc = m_tags.size();
    end
    if (acc) begin
      m_tags.push_back(m_pc);
      m_fetch++;
    end
    if (pc_src) m_pc = {new_pc[31:2], 2'b00};
    else if (acc) m_pc = m_pc + 32'd4;
  endtask

  task automatic drive_mem(input int rdy_pct, input int rv_pct, input int spur_pct);
    imem_ready = ($urandom_range(99) < rdy_pct);
    if (mem_pend.size() > 0) begin
      imem_rvalid = ($urandom_range(99) < rv_pct);
      imem_data   = imem_rvalid ? mem_word(mem_pend[0]) : $urandom;
    end else begin
      imem_rvalid = ($urandom_range(99) < spur_pct);
      imem_data   = $urandom;
    end
  endtask

  // One clock: capture the DUT's request, advance model and memory, return at negedge.
  task automatic tick();
    bit          dacc;
    logic [31:0] daddr;
    #1;
    dacc  = imem_read && imem_ready;
    daddr = imem_addr;
    @(posedge clk);
    model_edge();
    if (reset) mem_pend.delete();
    else begin
      if (imem_rvalid && mem_pend.size() > 0) void'(mem_pend.pop_front());
      if (dacc) mem_pend.push_back(daddr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    n_chk++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL reset_read: got %b expected 1", imem_read); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    n_chk++; if (if_id_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", if_id_instruction, NOP); end
    n_chk++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_id_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive_mem(100, 100, 0);
      #1;
      n_chk++; if (imem_read !== model_read()) begin n_fail++; $display("FAIL stream_read: got %b expected %b", imem_read, model_read()); end
      tick();
      n_chk++; if (if_id_pc !== m_id_pc || if_id_valid !== m_id_v) begin n_fail++; $display("FAIL stream_model: got %h/%b expected %h/%b", if_id_pc, if_id_valid, m_id_pc, m_id_v); end
      if (k == 3) begin
        n_chk++; if (if_id_pc !== 32'h0 || if_id_instruction !== 32'h0010_0093 || if_id_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_first: got %h %h %b expected 00000000 00100093 1", if_id_pc, if_id_instruction, if_id_valid); end
      end
      if (k == 4) begin
        n_chk++; if (if_id_pc !== 32'h4 || if_id_instruction !== 32'h0020_0113 || if_id_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_second: got %h %h %b expected 00000004 00200113 1", if_id_pc, if_id_instruction, if_id_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pcs [4];
    exp_pcs = '{32'h4, 32'h8, 32'hc, 32'h10};
    do_reset();
    for (int k = 0; k < 3; k++) begin drive_mem(100, 100, 0); tick(); end
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin drive_mem(100, 100, 0); tick(); end
    #1;
    n_chk++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL bp_read: got %b expected 0", imem_read); end
    n_chk++; if (if_id_pc !== 32'h0 || if_id_instruction !== 32'h0010_0093 || if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got %h %h %b expected 00000000 00100093 1", if_id_pc, if_id_instruction, if_id_valid); end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_mem(100, 100, 0);
      tick();
      n_chk++; if (if_id_pc !== exp_pcs[i] || if_id_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_pop%0d: got %h/%b expected %h/1", i, if_id_pc, if_id_valid, exp_pcs[i]); end
    end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset();
    imem_ready = 1'b1; imem_rvalid = 1'b0;
    tick(); tick();
    pc_src = 1'b1; new_pc = 32'h0000_1002;
    #1;
    n_chk++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL redir_read: got %b expected 0", imem_read); end
`ifdef IF_STAGE_FQ_PERF_EN
    n_chk++; if (perf_drop_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_drop_pre: got %0d expected 0", perf_drop_cnt); end
`endif
    tick();
    pc_src = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL redir_addr: got %h expected 00001000", imem_addr); end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      drive_mem(100, 100, 0);
      tick();
      if (if_id_valid === 1'b1) begin
        seen = 1'b1;
        n_chk++; if (if_id_pc !== 32'h0000_1000 || if_id_instruction !== mem_word(32'h1000)) begin
          n_fail++; $display("FAIL redir_first: got %h %h expected 00001000 %h", if_id_pc, if_id_instruction, mem_word(32'h1000)); end
      end
    end
    if (!seen) begin n_chk++; n_fail++; $display("FAIL redir_timeout: no valid instruction within 30 cycles"); end
`ifdef IF_STAGE_FQ_PERF_EN
    n_chk++; if (perf_drop_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_drop: got %0d expected 2", perf_drop_cnt); end
`endif
  endtask

  task automatic test_flush_stall();
    bit seen;
    do_reset();
    for (int k = 0; k < 3; k++) begin drive_mem(100, 100, 0); tick(); end
    stall = 1'b1;
    drive_mem(100, 100, 0);
    tick();
    flush = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    n_chk++; if (if_id_pc !== 32'h0 || if_id_instruction !== NOP || if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_ifid: got %h %h %b expected 00000000 00000013 0", if_id_pc, if_id_instruction, if_id_valid); end
    n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL flush_pc: got %h expected 00000010", imem_addr); end
    stall = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      drive_mem(100, 100, 0);
      #1;
      if (imem_read === 1'b1) begin
        seen = 1'b1;
        n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL flush_resume: got %h expected 00000010", imem_addr); end
      end
      tick();
    end
    if (!seen) begin n_chk++; n_fail++; $display("FAIL flush_timeout: fetch did not resume within 10 cycles"); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(199) == 0);
      flush  = ($urandom_range(99) < 3);
      pc_src = ($urandom_range(99) < 4);
      new_pc = $urandom;
      stall  = ($urandom_range(99) < 30);
      drive_mem(70, 60, 10);
      #1;
      n_chk++; if (imem_read !== model_read()) begin n_fail++; $display("FAIL rnd_read @%0d: got %b expected %b", c, imem_read, model_read()); end
      n_chk++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h expected %h", c, imem_addr, m_pc); end
      n_chk++; if (if_id_pc !== m_id_pc) begin n_fail++; $display("FAIL rnd_pc @%0d: got %h expected %h", c, if_id_pc, m_id_pc); end
      n_chk++; if (if_id_instruction !== m_id_ins) begin n_fail++; $display("FAIL rnd_instr @%0d: got %h expected %h", c, if_id_instruction, m_id_ins); end
      n_chk++; if (if_id_valid !== m_id_v) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b expected %b", c, if_id_valid, m_id_v); end
      tick();
    end
    reset = 1'b0; flush = 1'b0; pc_src = 1'b0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    #1;
`ifdef IF_STAGE_FQ_PERF_EN
    n_chk++; if (perf_fetch_cnt !== m_fetch) begin n_fail++; $display("FAIL rnd_perf_fetch: got %0d expected %0d", perf_fetch_cnt, m_fetch); end
    n_chk++; if (perf_drop_cnt !== m_drops) begin n_fail++; $display("FAIL rnd_perf_drop: got %0d expected %0d", perf_drop_cnt, m_drops); end
    n_chk++; if (perf_bubble_cnt !== m_bubbles) begin n_fail++; $display("FAIL rnd_perf_bubble: got %0d expected %0d", perf_bubble_cnt, m_bubbles); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_flush_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
